// File: rtl/adc_sample_receiver_pkg.sv
// Shared types and defaults for the ADC sample receiver.
// Sample type, default widths and receiver state encoding.
package adc_pkg;

  localparam int ADC_DATA_W   = 12;
  localparam int ADC_LOG2_AVG = 4;

  typedef logic [ADC_DATA_W-1:0] adc_sample_t;

  typedef enum logic {
    IDLE,
    ACCUM
  } rx_state_t;

endpackage

// File: rtl/adc_sample_receiver_if.sv
// ADC strobe/data in, raw and averaged results out.
// slave = receiver side, master = ADC + NCO control side.
interface adc_sample_receiver_if #(
  parameter int DATA_W = 12,
  parameter int IDX_W  = 4
);

  logic              response_valid_in;
  logic [DATA_W-1:0] adc_data_in;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic [DATA_W-1:0] avg_out;
  logic              avg_valid;
  logic [IDX_W-1:0]  sample_idx;

  modport master (
    output response_valid_in,
    output adc_data_in,
    input  sample_out,
    input  sample_valid,
    input  avg_out,
    input  avg_valid,
    input  sample_idx
  );

  modport slave (
    input  response_valid_in,
    input  adc_data_in,
    output sample_out,
    output sample_valid,
    output avg_out,
    output avg_valid,
    output sample_idx
  );

endinterface

// File: rtl/strobe_sync_edge.sv
// Synchronises an async strobe and emits a registered rise pulse.
// Ports: MAX10_CLK1_50, reset_n (sync, low), strobe_in -> rise.
module strobe_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic MAX10_CLK1_50,
  input  logic reset_n,
  input  logic strobe_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!reset_n) begin
      sync <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], strobe_in};
      prev <= sync[SYNC_STAGES-1];
      rise <= sync[SYNC_STAGES-1] & ~prev;
    end
  end

endmodule

// File: rtl/adc_sample_receiver.sv
// Captures ADC samples per strobe and block-averages 2^LOG2_AVG.
// Ports: MAX10_CLK1_50, reset_n, enable, bus (slave modport).
module adc_sample_receiver
  import adc_pkg::*;
#(
  parameter int DATA_W      = ADC_DATA_W,
  parameter int LOG2_AVG    = ADC_LOG2_AVG,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  MAX10_CLK1_50,
  input  logic                  reset_n,
  input  logic                  enable,
  adc_sample_receiver_if.slave  bus
);

  localparam int IDX_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int ACC_W = DATA_W + LOG2_AVG;
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'((1 << LOG2_AVG) - 1);

  rx_state_t         state;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  sum;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] smp_q;
  logic [DATA_W-1:0] avg_q;
  logic              smp_v;
  logic              avg_v;
  logic              rise;

  strobe_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .MAX10_CLK1_50(MAX10_CLK1_50),
    .reset_n      (reset_n),
    .strobe_in    (bus.response_valid_in),
    .rise         (rise)
  );

  assign sum = acc + ACC_W'(bus.adc_data_in);

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!reset_n) begin
      state <= IDLE;
      acc   <= '0;
      idx   <= '0;
      smp_q <= '0;
      avg_q <= '0;
      smp_v <= 1'b0;
      avg_v <= 1'b0;
    end else begin
      smp_v <= 1'b0;
      avg_v <= 1'b0;
      unique case (state)
        IDLE: begin
          acc <= '0;
          idx <= '0;
          if (enable) state <= ACCUM;
        end
        ACCUM: begin
          // enable wins over a coincident edge
          if (!enable) begin
            state <= IDLE;
            acc   <= '0;
            idx   <= '0;
          end else if (rise) begin
            smp_q <= bus.adc_data_in;
            smp_v <= 1'b1;
            if (idx == IDX_LAST) begin
              avg_q <= DATA_W'(sum >> LOG2_AVG);
              avg_v <= 1'b1;
              acc   <= '0;
              idx   <= '0;
            end else begin
              acc <= sum;
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sample_out   = smp_q;
  assign bus.sample_valid = smp_v;
  assign bus.avg_out      = avg_q;
  assign bus.avg_valid    = avg_v;
  assign bus.sample_idx   = idx;

endmodule

// File: tb/tb_adc_sample_receiver.sv
// Scoreboard bench: default build plus a LOG2_AVG=0 build.
// Both share strobe, data, enable and reset.
module tb_adc_sample_receiver;
  import adc_pkg::*;

  logic clk;
  logic reset_n;
  logic enable;
  logic en_model;
  int   tests;
  int   fails;
  int   pulse0;

  adc_sample_t q0s[$];
  adc_sample_t q0a[$];
  adc_sample_t q1s[$];
  adc_sample_t q1a[$];

  adc_sample_receiver_if #(.DATA_W(12), .IDX_W(4)) if0 ();
  adc_sample_receiver_if #(.DATA_W(12), .IDX_W(1)) if1 ();

  assign if1.response_valid_in = if0.response_valid_in;
  assign if1.adc_data_in       = if0.adc_data_in;

  adc_sample_receiver dut0 (
    .MAX10_CLK1_50(clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .bus          (if0)
  );

  adc_sample_receiver #(
    .DATA_W     (12),
    .LOG2_AVG   (0),
    .SYNC_STAGES(2)
  ) dut1 (
    .MAX10_CLK1_50(clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .bus          (if1)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_chk(input string name, input int act,
                         inout adc_sample_t q[$]);
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: unexpected output %0d", name, act);
    end else begin
      chk(name, act, int'(q.pop_front()));
    end
  endtask

  always @(negedge clk) begin
    if (if0.sample_valid) begin
      pulse0++;
      pop_chk("dut0 sample", int'(if0.sample_out), q0s);
    end
    if (if0.avg_valid)
      pop_chk("dut0 avg", int'(if0.avg_out), q0a);
  end

  always @(negedge clk) begin
    if (if1.sample_valid)
      pop_chk("dut1 sample", int'(if1.sample_out), q1s);
    if (if1.avg_valid)
      pop_chk("dut1 avg", int'(if1.avg_out), q1a);
    if (if1.avg_valid != if1.sample_valid)
      chk("dut1 avg_valid==sample_valid",
          int'(if1.avg_valid), int'(if1.sample_valid));
  end

  // One strobe, 100 clocks total; exp_avg < 0 means no block completes.
  task automatic send(input int d, input int exp_avg = -1);
    @(posedge clk);
    #1;
    if0.adc_data_in       = 12'(d);
    if0.response_valid_in = 1'b1;
    if (en_model) begin
      q0s.push_back(12'(d));
      if (exp_avg >= 0) q0a.push_back(12'(exp_avg));
      q1s.push_back(12'(d));
      q1a.push_back(12'(d));
    end
    repeat (2) @(posedge clk);
    #1 if0.response_valid_in = 1'b0;
    repeat (97) @(posedge clk);
  endtask

  task automatic set_en(input logic v);
    @(posedge clk);
    #1;
    enable   = v;
    en_model = v;
  endtask

  initial begin
    int p;
    tests    = 0;
    fails    = 0;
    pulse0   = 0;
    reset_n  = 1'b0;
    enable   = 1'b0;
    en_model = 1'b0;
    if0.response_valid_in = 1'b0;
    if0.adc_data_in       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset sample_out", int'(if0.sample_out), 0);
    chk("reset avg_out", int'(if0.avg_out), 0);
    chk("reset sample_valid", int'(if0.sample_valid), 0);
    chk("reset avg_valid", int'(if0.avg_valid), 0);
    chk("reset sample_idx", int'(if0.sample_idx), 0);
    reset_n = 1'b1;
    set_en(1'b1);
    repeat (3) @(posedge clk);

    // latency: strobe first sampled at E0, pulse after E3
    @(posedge clk);
    #1;
    if0.adc_data_in       = 12'd55;
    if0.response_valid_in = 1'b1;
    q0s.push_back(12'd55);
    q1s.push_back(12'd55);
    q1a.push_back(12'd55);
    repeat (3) @(posedge clk);
    #1 chk("latency E2 low", int'(if0.sample_valid), 0);
    if0.response_valid_in = 1'b0;
    @(posedge clk);
    #1 chk("latency E3 high", int'(if0.sample_valid), 1);
    @(posedge clk);
    #1 chk("latency E4 low", int'(if0.sample_valid), 0);
    repeat (20) @(posedge clk);

    // strobe held 500 ns counts once
    p = pulse0;
    @(posedge clk);
    #1;
    if0.adc_data_in       = 12'd66;
    if0.response_valid_in = 1'b1;
    q0s.push_back(12'd66);
    q1s.push_back(12'd66);
    q1a.push_back(12'd66);
    repeat (25) @(posedge clk);
    #1 if0.response_valid_in = 1'b0;
    repeat (40) @(posedge clk);
    chk("held strobe pulses", pulse0 - p, 1);

    // flush; a strobe while idle must be ignored
    set_en(1'b0);
    repeat (5) @(posedge clk);
    send(77);
    set_en(1'b1);
    repeat (3) @(posedge clk);

    for (int i = 1; i <= 32; i++)
      send(i, (i == 16) ? 8 : (i == 32) ? 24 : -1);
    for (int i = 0; i < 16; i++)
      send(4095, (i == 15) ? 4095 : -1);
    for (int i = 0; i < 16; i++)
      send(0, (i == 15) ? 0 : -1);

    for (int i = 0; i < 7; i++) send(50);
    #1 chk("idx after 7", int'(if0.sample_idx), 7);
    set_en(1'b0);
    repeat (10) @(posedge clk);
    set_en(1'b1);
    repeat (2) @(posedge clk);
    #1 chk("idx after flush", int'(if0.sample_idx), 0);
    for (int i = 0; i < 16; i++)
      send(100 + i, (i == 15) ? 107 : -1);

    for (int i = 0; i < 5; i++) send(9);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("mid reset sample_out", int'(if0.sample_out), 0);
    chk("mid reset avg_out", int'(if0.avg_out), 0);
    chk("mid reset idx", int'(if0.sample_idx), 0);
    chk("mid reset dut1 avg_out", int'(if1.avg_out), 0);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 16; i++)
      send(8, (i == 15) ? 8 : -1);

    send(2);
    send(1000);
    send(4095);
    #1;
    chk("dut0 idx partial", int'(if0.sample_idx), 3);
    chk("dut1 idx", int'(if1.sample_idx), 0);
    chk("dut1 last avg_out", int'(if1.avg_out), 4095);

    repeat (10) @(posedge clk);
    chk("dut0 samples left", q0s.size(), 0);
    chk("dut0 avgs left", q0a.size(), 0);
    chk("dut1 samples left", q1s.size(), 0);
    chk("dut1 avgs left", q1a.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
